// File: rtl/gray_video_pattern_gen_pkg.sv
// Shared video definitions for the gray pattern source:
// FSM states, pattern codes and default 640x480 timing.
package gray_video_pattern_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBACK,
    ST_ACTIVE,
    ST_VFRONT
  } vstate_e;

  localparam logic [1:0] PAT_HRAMP = 2'd0;
  localparam logic [1:0] PAT_VRAMP = 2'd1;
  localparam logic [1:0] PAT_CHECK = 2'd2;
  localparam logic [1:0] PAT_FCNT  = 2'd3;

  localparam logic [10:0] DEF_HDISP  = 11'd640;
  localparam logic [10:0] DEF_VDISP  = 11'd480;
  localparam logic [10:0] DEF_HBLANK = 11'd160;
  localparam logic [10:0] DEF_VSYNC  = 11'd2;
  localparam logic [10:0] DEF_VBACK  = 11'd33;
  localparam logic [10:0] DEF_VFRONT = 11'd10;

endpackage

// File: rtl/gray_video_pattern_gen_timing.sv
// video_timing_counter: h/v counters and frame FSM.
// Ports: clk, rst, i_enable in; o_state, o_x, o_y, o_last_pixel out.
module video_timing_counter
  import gray_video_pattern_gen_pkg::*;
#(
  parameter logic [10:0] IMG_HDISP = DEF_HDISP,
  parameter logic [10:0] IMG_VDISP = DEF_VDISP,
  parameter logic [10:0] H_BLANK   = DEF_HBLANK,
  parameter logic [10:0] V_SYNC    = DEF_VSYNC,
  parameter logic [10:0] V_BACK    = DEF_VBACK,
  parameter logic [10:0] V_FRONT   = DEF_VFRONT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_enable,
  output vstate_e     o_state,
  output logic [10:0] o_x,
  output logic [7:0]  o_y,
  output logic        o_last_pixel
);

  localparam logic [10:0] HTOTAL = IMG_HDISP + H_BLANK;

  vstate_e     r_state;
  vstate_e     w_next;
  logic [10:0] r_h_cnt;
  logic [10:0] r_v_cnt;
  logic [10:0] w_last_v;
  logic        w_h_wrap;
  logic        w_line_end;

  // last line index of the current state
  always_comb begin
    w_last_v = '0;
    unique case (r_state)
      ST_VSYNC:  w_last_v = V_SYNC - 11'd1;
      ST_VBACK:  w_last_v = V_BACK - 11'd1;
      ST_ACTIVE: w_last_v = IMG_VDISP - 11'd1;
      ST_VFRONT: w_last_v = V_FRONT - 11'd1;
      default:   w_last_v = '0;
    endcase
  end

  assign w_h_wrap   = (r_h_cnt == HTOTAL - 11'd1);
  assign w_line_end = w_h_wrap && (r_v_cnt == w_last_v);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:   if (i_enable)   w_next = ST_VSYNC;
      ST_VSYNC:  if (w_line_end) w_next = ST_VBACK;
      ST_VBACK:  if (w_line_end) w_next = ST_ACTIVE;
      ST_ACTIVE: if (w_line_end) w_next = ST_VFRONT;
      ST_VFRONT:
        if (w_line_end)
          w_next = i_enable ? ST_VSYNC : ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_state == ST_IDLE) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else begin
      r_h_cnt <= w_h_wrap ? '0 : r_h_cnt + 11'd1;
      if (w_h_wrap)
        r_v_cnt <= w_line_end ? '0 : r_v_cnt + 11'd1;
    end
  end

  assign o_state      = r_state;
  assign o_x          = r_h_cnt;
  assign o_y          = r_v_cnt[7:0];
  assign o_last_pixel = (r_state == ST_VFRONT) && w_line_end;

endmodule

// File: rtl/gray_video_pattern_gen.sv
// Gray test-pattern video source with vsync/href framing.
// Ports: clk, rst, enable, pattern_sel in; post_frame_*, Gray, frame_done, busy out.
module gray_video_pattern_gen
  import gray_video_pattern_gen_pkg::*;
#(
  parameter logic [10:0] IMG_HDISP = DEF_HDISP,
  parameter logic [10:0] IMG_VDISP = DEF_VDISP,
  parameter logic [10:0] H_BLANK   = DEF_HBLANK,
  parameter logic [10:0] V_SYNC    = DEF_VSYNC,
  parameter logic [10:0] V_BACK    = DEF_VBACK,
  parameter logic [10:0] V_FRONT   = DEF_VFRONT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] pattern_sel,
  output logic       post_frame_vsync,
  output logic       post_frame_href,
  output logic [7:0] post_img_Gray,
  output logic       frame_done,
  output logic       busy
);

  vstate_e     w_state;
  logic [10:0] w_x;
  logic [7:0]  w_y;
  logic        w_last;
  logic        w_href;
  logic        w_start;
  logic [7:0]  w_gray;
  logic [1:0]  r_pat;
  logic [7:0]  r_fcnt;

  video_timing_counter #(
    .IMG_HDISP (IMG_HDISP),
    .IMG_VDISP (IMG_VDISP),
    .H_BLANK   (H_BLANK),
    .V_SYNC    (V_SYNC),
    .V_BACK    (V_BACK),
    .V_FRONT   (V_FRONT)
  ) u_timing (
    .clk          (clk),
    .rst          (rst),
    .i_enable     (enable),
    .o_state      (w_state),
    .o_x          (w_x),
    .o_y          (w_y),
    .o_last_pixel (w_last)
  );

  assign w_href = (w_state == ST_ACTIVE) && (w_x < IMG_HDISP);

  // same edge on which the counters enter VSYNC
  assign w_start = enable && ((w_state == ST_IDLE) || w_last);

  always_comb begin
    w_gray = 8'h00;
    if (w_href) begin
      unique case (r_pat)
        PAT_HRAMP: w_gray = w_x[7:0];
        PAT_VRAMP: w_gray = w_y;
        PAT_CHECK: w_gray = (w_x[3] ^ w_y[3]) ? 8'hFF : 8'h00;
        PAT_FCNT:  w_gray = r_fcnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pat            <= PAT_HRAMP;
      r_fcnt           <= '0;
      post_frame_vsync <= 1'b0;
      post_frame_href  <= 1'b0;
      post_img_Gray    <= '0;
      frame_done       <= 1'b0;
      busy             <= 1'b0;
    end else begin
      if (w_start) r_pat  <= pattern_sel;
      if (w_last)  r_fcnt <= r_fcnt + 8'd1;
      post_frame_vsync <= (w_state == ST_VSYNC);
      post_frame_href  <= w_href;
      post_img_Gray    <= w_gray;
      frame_done       <= w_last;
      busy             <= (w_state != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_gray_video_pattern_gen.sv
// Bench for gray_video_pattern_gen: random pattern sequences
// checked cycle by cycle against an arithmetic frame model.
module tb_gray_video_pattern_gen;

  localparam int HB  = 4;
  localparam int VS  = 1;
  localparam int VB  = 1;
  localparam int VF  = 1;
  localparam int HD1 = 8;
  localparam int VD1 = 4;
  localparam int HT1 = HD1 + HB;
  localparam int HD2 = 16;
  localparam int VD2 = 16;
  localparam int HT2 = HD2 + HB;

  logic       clk;
  logic       rst;
  logic       en1, en2;
  logic [1:0] sel1, sel2;
  logic       vs1, hr1, fd1, bz1;
  logic       vs2, hr2, fd2, bz2;
  logic [7:0] g1, g2;
  logic [11:0] w_obs1, w_obs2;

  int n_chk  = 0;
  int n_fail = 0;
  int fcnt   = 0;
  int cur_pat = 0;

  assign w_obs1 = {vs1, hr1, g1, fd1, bz1};
  assign w_obs2 = {vs2, hr2, g2, fd2, bz2};

  gray_video_pattern_gen #(
    .IMG_HDISP (11'd8),
    .IMG_VDISP (11'd4),
    .H_BLANK   (11'd4),
    .V_SYNC    (11'd1),
    .V_BACK    (11'd1),
    .V_FRONT   (11'd1)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .enable           (en1),
    .pattern_sel      (sel1),
    .post_frame_vsync (vs1),
    .post_frame_href  (hr1),
    .post_img_Gray    (g1),
    .frame_done       (fd1),
    .busy             (bz1)
  );

  gray_video_pattern_gen #(
    .IMG_HDISP (11'd16),
    .IMG_VDISP (11'd16),
    .H_BLANK   (11'd4),
    .V_SYNC    (11'd1),
    .V_BACK    (11'd1),
    .V_FRONT   (11'd1)
  ) dut2 (
    .clk              (clk),
    .rst              (rst),
    .enable           (en2),
    .pattern_sel      (sel2),
    .post_frame_vsync (vs2),
    .post_frame_href  (hr2),
    .post_img_Gray    (g2),
    .frame_done       (fd2),
    .busy             (bz2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected {vsync, href, gray, done, busy} at cycle t of a frame
  function automatic logic [11:0] model(input int t, input int pat,
                                         input int fc, input int hd,
                                         input int vd);
    int ht, per, ln, x, y;
    logic vs, hr, dn;
    logic [7:0] g;
    ht  = hd + HB;
    per = ht * (VS + VB + vd + VF);
    ln  = t / ht;
    x   = t % ht;
    y   = ln - VS - VB;
    vs  = (ln < VS);
    hr  = (y >= 0) && (y < vd) && (x < hd);
    g   = 8'h00;
    if (hr) begin
      case (pat)
        0: g = 8'(x);
        1: g = 8'(y);
        2: g = ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? 8'hFF : 8'h00;
        default: g = 8'(fc % 256);
      endcase
    end
    dn = (t == per - 1);
    return {vs, hr, g, dn, 1'b1};
  endfunction

  // runs nfr back-to-back frames on dut; fix>=0 forces next pattern,
  // drop_t>=0 drops enable at that cycle of the last frame
  task automatic test_stream(input string name, input int nfr,
                             input int fix, input int drop_t);
    int per, nh, nv, nxt;
    logic [11:0] e;
    per = HT1 * (VS + VB + VD1 + VF);
    for (int f = 0; f < nfr; f++) begin
      nh  = 0;
      nv  = 0;
      nxt = cur_pat;
      for (int t = 0; t < per; t++) begin
        if (t == 20) sel1 = 2'($urandom);
        if (t == 40) begin
          nxt  = (fix >= 0) ? fix : int'($urandom_range(0, 3));
          sel1 = 2'(nxt);
        end
        if (f == nfr - 1 && t == drop_t) begin
          en1  = 1'b0;
          sel1 = 2'(cur_pat + 1);
        end
        @(negedge clk);
        e = model(t, cur_pat, fcnt, HD1, VD1);
        n_chk++;
        if (w_obs1 !== e) begin
          n_fail++;
          $display("FAIL %s f=%0d t=%0d got %h expected %h",
                   name, f, t, w_obs1, e);
        end
        nh += int'(hr1);
        nv += int'(vs1);
      end
      n_chk++;
      if (nh != HD1 * VD1) begin
        n_fail++;
        $display("FAIL %s_href_cnt got %0d expected %0d",
                 name, nh, HD1 * VD1);
      end
      n_chk++;
      if (nv != HT1 * VS) begin
        n_fail++;
        $display("FAIL %s_vsync_cnt got %0d expected %0d",
                 name, nv, HT1 * VS);
      end
      fcnt    = (fcnt + 1) % 256;
      cur_pat = nxt;
    end
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    en1  = 1'b0;
    en2  = 1'b0;
    sel1 = 2'd0;
    sel2 = 2'd0;
    repeat (2) @(negedge clk);
    n_chk++;
    if (w_obs1 !== 12'h000) begin
      n_fail++;
      $display("FAIL reset1 got %h expected 000", w_obs1);
    end
    n_chk++;
    if (w_obs2 !== 12'h000) begin
      n_fail++;
      $display("FAIL reset2 got %h expected 000", w_obs2);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (w_obs1 !== 12'h000) begin
      n_fail++;
      $display("FAIL idle got %h expected 000", w_obs1);
    end
  endtask

  task automatic test_checker();
    int per;
    logic [11:0] e;
    logic [7:0] p80, p08, p88, p00;
    per  = HT2 * (VS + VB + VD2 + VF);
    sel2 = 2'd2;
    en2  = 1'b1;
    @(negedge clk);
    for (int t = 0; t < per; t++) begin
      if (t == 100) begin
        en2  = 1'b0;
        sel2 = 2'($urandom);
      end
      @(negedge clk);
      e = model(t, 2, 0, HD2, VD2);
      n_chk++;
      if (w_obs2 !== e) begin
        n_fail++;
        $display("FAIL check t=%0d got %h expected %h", t, w_obs2, e);
      end
      if (t == 2 * HT2 + 8)           p80 = g2;
      if (t == 10 * HT2)              p08 = g2;
      if (t == 10 * HT2 + 8)          p88 = g2;
      if (t == 2 * HT2)               p00 = g2;
    end
    n_chk++;
    if (p80 !== 8'hFF || p08 !== 8'hFF) begin
      n_fail++;
      $display("FAIL check_ff got %h %h expected ff ff", p80, p08);
    end
    n_chk++;
    if (p88 !== 8'h00 || p00 !== 8'h00) begin
      n_fail++;
      $display("FAIL check_00 got %h %h expected 00 00", p88, p00);
    end
    @(negedge clk);
    n_chk++;
    if (w_obs2 !== 12'h000) begin
      n_fail++;
      $display("FAIL check_idle got %h expected 000", w_obs2);
    end
  endtask

  task automatic test_hramp();
    sel1    = 2'd0;
    cur_pat = 0;
    en1     = 1'b1;
    @(negedge clk);
    n_chk++;
    if (w_obs1 !== 12'h000) begin
      n_fail++;
      $display("FAIL hramp_lat got %h expected 000", w_obs1);
    end
    test_stream("hramp", 1, 1, -1);
  endtask

  task automatic test_back_to_back();
    test_stream("b2b", 3, -1, -1);
  endtask

  task automatic test_fcnt_wrap();
    test_stream("fcnt", 257, 3, -1);
  endtask

  task automatic test_enable_drop();
    int d;
    d = $urandom_range(41, 70);
    test_stream("drop", 1, -1, d);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_chk++;
      if (w_obs1 !== 12'h000) begin
        n_fail++;
        $display("FAIL drop_idle i=%0d got %h expected 000", i, w_obs1);
      end
    end
  endtask

  task automatic test_rst_mid();
    int n;
    logic [11:0] e;
    sel1    = 2'd0;
    cur_pat = 0;
    en1     = 1'b1;
    @(negedge clk);
    n = $urandom_range(30, 60);
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      e = model(t, 0, fcnt, HD1, VD1);
      n_chk++;
      if (w_obs1 !== e) begin
        n_fail++;
        $display("FAIL rst_pre t=%0d got %h expected %h", t, w_obs1, e);
      end
    end
    rst = 1'b1;
    #1;
    n_chk++;
    if (w_obs1 !== 12'h000) begin
      n_fail++;
      $display("FAIL rst_async got %h expected 000", w_obs1);
    end
    @(negedge clk);
    rst  = 1'b0;
    fcnt = 0;
    @(negedge clk);
    n_chk++;
    if (w_obs1 !== 12'h000) begin
      n_fail++;
      $display("FAIL rst_release got %h expected 000", w_obs1);
    end
    test_stream("restart", 1, -1, -1);
  endtask

  initial begin
    test_reset();
    test_checker();
    test_hramp();
    test_back_to_back();
    test_fcnt_wrap();
    test_enable_drop();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_video_pattern_gen.md
# gray_video_pattern_gen

Source of the 8-bit gray video stream consumed by the image-processing filters (median, mean, Sobel, etc.). Generates frame timing (vsync, href) and a selectable deterministic test pattern, using the same per-pixel stream protocol those filters expect on their per_frame_* inputs. Used as on-chip stimulus for filter bring-up and as the driving end in filter simulation benches.

## Interface
- IMG_HDISP, 11'd640: active pixels per line
- IMG_VDISP, 11'd480: active lines per frame
- H_BLANK, 11'd160: blank cycles after each line's active pixels, ≥1
- V_SYNC, 11'd2: lines with vsync asserted, ≥1
- V_BACK, 11'd33: blank lines after sync, before active, ≥1
- V_FRONT, 11'd10: blank lines after active, ≥1
- clk  in  1  pixel clock, one pixel per cycle
- rst  in  1  reset, asynchronous, active-high (one clock; asynchronous active-high reset)
- enable  in  1  run frames; sampled at frame boundaries only
- pattern_sel  in  2  0 h-ramp, 1 v-ramp, 2 checkerboard, 3 flat frame count
- post_frame_vsync  out  1  frame sync, high during V_SYNC lines
- post_frame_href  out  1  high for active pixels only
- post_img_Gray  out  8  pixel value; 0 whenever href low
- frame_done  out  1  one-cycle pulse at end of each frame
- busy  out  1  high whenever state ≠ IDLE

## Operation
- HTOTAL = IMG_HDISP + H_BLANK. h_cnt 0..HTOTAL-1, v_cnt counts lines within the current state; both 11 bits.
- States: IDLE → VSYNC (V_SYNC lines) → VBACK (V_BACK lines) → ACTIVE (IMG_VDISP lines) → VFRONT (V_FRONT lines) → VSYNC if enable else IDLE.
- IDLE: counters held at 0, all outputs 0. enable=1 → VSYNC at next edge.
- h_cnt wraps at HTOTAL-1; state advances on the wrap of its last line; v_cnt clears on each state change.
- vsync = (state==VSYNC) for entire lines, including blank cycles.
- href = (state==ACTIVE) && h_cnt < IMG_HDISP. x = h_cnt, y = active line index.
- Pattern (latched into pat_r at VSYNC entry; mid-frame pattern_sel changes ignored):
  - 0: Gray = x[7:0]
  - 1: Gray = y[7:0]
  - 2: Gray = (x[3]^y[3]) ? 8'hFF : 8'h00
  - 3: Gray = frame_cnt
- frame_cnt: 8-bit, 0 after reset, increments at every frame_done, wraps 255→0.
- frame_done: high on the output cycle of the last pixel of the last VFRONT line.
- enable deassert mid-frame: current frame completes unchanged, then IDLE.

## Timing
- All outputs registered; reset values: vsync 0, href 0, Gray 0, frame_done 0, busy 0; state IDLE, counters and frame_cnt 0, pat_r 0.
- Counters update at edge k; outputs reflect that position after edge k+1 (one-cycle output latency, uniform for all outputs).
- enable high at edge k in IDLE → counters start at edge k → first vsync high after edge k+1.
- Frame period = HTOTAL × (V_SYNC+V_BACK+IMG_VDISP+V_FRONT) cycles; back-to-back frames have no idle cycles.
- rst asserted mid-frame: all outputs 0 asynchronously; restart only from IDLE with a full VSYNC.

## Structure
- Shared video package: state enum (IDLE, VSYNC, VBACK, ACTIVE, VFRONT), pattern codes PAT_HRAMP/PAT_VRAMP/PAT_CHECK/PAT_FCNT, default 640×480 timing constants.
- One sub-module: video_timing_counter (h/v counters + state machine, emits state, x, y, last_pixel_of_frame); the top adds pattern mux, frame_cnt and output registers.

## Test plan
Small params: HDISP=8, VDISP=4, H_BLANK=4, V_SYNC=1, V_BACK=1, V_FRONT=1 → HTOTAL=12, frame=84 cycles.
- Reset then enable=1, pattern 0 → vsync high 12 cycles starting 2 edges after enable; each active line Gray 0..7 with href high 8 cycles, 0 in 4 blank cycles; 32 href cycles per frame.
- pattern 1 → active lines carry 0,1,2,3 constant per line; frame_done pulses every 84 cycles.
- pattern 2 with HDISP=16, VDISP=16 → pixel (8,0)=FF, (0,8)=FF, (8,8)=00, (0,0)=00.
- pattern 3, 257 frames → Gray equals frame index, frame 256 outputs 0 (wrap).
- enable dropped and pattern_sel changed mid-ACTIVE → frame completes with old pattern, busy falls after frame_done, outputs stay 0.
- rst pulse mid-ACTIVE → outputs 0 same cycle; after release with enable=1, new frame begins with vsync.
